nibbler_branch_ctrl: RTL
========================

// Module: nibbler_branch_ctrl
// PURPOSE
//  Consumer side of the Flags register: owns the program counter and reads zero/carry
//  to resolve conditional jumps. Runs a two-phase FETCH/EXEC sequence per instruction.
//  Sits between program memory (instr) and the Flags module outputs (zero_out, carry_out).
//  Stalls one EXEC cycle when the flags are being rewritten under a conditional jump.
// PARAMETERS
//  ADDR_W  12  PC / jump-target width (1..12); target = ir[ADDR_W-1:0]
//  CNT_W   8   width of the saturating taken-branch counter
// PORTS
//  clk           in   1        single clock, all state on rising edge
//  reset         in   1        synchronous, active-high; overrides everything
//  enable        in   1        advance phase; 0 = every register holds
//  instr         in   16       program word: [15:12] opcode, [11:0] address/immediate
//  zero          in   1        from Flags zero_out
//  carry         in   1        from Flags carry_out
//  flags_wr      in   1        Flags enable: flags update at this clock edge
//  pc            out  ADDR_W   program counter (memory address of next fetch)
//  phase         out  1        0 = FETCH, 1 = EXEC
//  branch_taken  out  1        1-cycle pulse after an EXEC that loaded the jump target
//  stall         out  1        high for each cycle spent held in EXEC on a flag hazard
//  taken_count   out  CNT_W    saturating count of taken jumps
// BEHAVIOUR
//  - Reset (sync, active-high): state=FETCH, pc=0, ir=0, phase=0, branch_taken=0,
//    stall=0, taken_count=0. Reset mid-EXEC discards the pending instruction.
//  - enable=0: pc, ir, state, taken_count hold; branch_taken and stall drive 0 next cycle.
//  - FETCH & enable: ir <= instr; state -> EXEC. pc unchanged.
//  - EXEC & enable, conditional jump (JC/JNC/JZ/JNZ) & flags_wr=1: state stays EXEC,
//    pc holds, stall<=1. Repeats while flags_wr stays 1; evaluates on first flags_wr=0 cycle.
//  - EXEC & enable otherwise: taken = cond(opcode, zero, carry);
//    pc <= taken ? ir[ADDR_W-1:0] : pc+1 (mod 2^ADDR_W, 0xFFF -> 0x000);
//    branch_taken<=taken; taken_count += taken, saturating at 2^CNT_W-1; state -> FETCH.
//  - JMP and non-jump opcodes ignore flags_wr (no stall).
//  - cond: JC(0000) carry=1; JNC(0001) carry=0; JZ(1000) zero=1; JNZ(1001) zero=0;
//    JMP(1100) always; all other opcodes never taken.
//  - Latency: 2 cycles/instruction unstalled; pc valid for the next FETCH on the edge
//    ending EXEC. Flags are sampled in the cycle the EXEC edge occurs, not at fetch.
//  - All outputs registered; no combinational input->output path.
// STRUCTURE
//  - nibbler_pkg: opcode_t enum (16 Nibbler opcodes, codes above), phase_t {FETCH, EXEC},
//    OPC_MSB/OPC_LSB field constants.
//  - Sub-module branch_cond_eval: combinational (opcode, zero, carry) -> taken, is_cond.
//  - Top holds FSM, ir, pc, counter and the hazard/stall logic.
// TESTING
//  1. Run to pc=0x005 in EXEC, assert reset 1 cycle -> pc=0x000, phase=0, taken_count=0.
//  2. JZ 0x123, zero=1 -> pc=0x123, branch_taken=1 one cycle, taken_count=1;
//     repeat with zero=0 -> pc=prev+1, branch_taken=0.
//  3. carry=1: JC 0x0A0 -> pc=0x0A0; then JNC 0x0B0 -> pc=0x0A1, count unchanged.
//  4. JNZ 0x050, zero=1, flags_wr=1 in EXEC while Flags clears zero -> stall=1 one
//     cycle, pc holds; next cycle zero=0 -> pc=0x050, branch_taken=1.
//  5. pc=0xFFF, LIT (0100) -> pc=0x000, branch_taken=0; JMP with taken_count=255 -> stays 255.
//  6. enable=0 for 3 cycles mid-EXEC of JMP 0x200 -> pc/phase hold; enable=1 -> pc=0x200.

Source files
------------

// File: rtl/nibbler_pkg.sv
// Shared types for the Nibbler branch controller: opcode encoding,
// instruction phase and instruction-word field positions.
package nibbler_pkg;

    // Full Nibbler opcode map; only the jump opcodes matter to branching.
    typedef enum logic [3:0] {
        OP_JC   = 4'b0000,
        OP_JNC  = 4'b0001,
        OP_CMPI = 4'b0010,
        OP_CMPM = 4'b0011,
        OP_LIT  = 4'b0100,
        OP_IN   = 4'b0101,
        OP_LD   = 4'b0110,
        OP_ST   = 4'b0111,
        OP_JZ   = 4'b1000,
        OP_JNZ  = 4'b1001,
        OP_ADDI = 4'b1010,
        OP_ADDM = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_OUT  = 4'b1101,
        OP_NORI = 4'b1110,
        OP_NORM = 4'b1111
    } opcode_t;

    // Two-phase instruction sequence; the encoding doubles as the phase output.
    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } phase_t;

    // Opcode field position inside the 16-bit program word.
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational jump-condition decoder: decides whether the current opcode
// jumps given the flags, and whether it depends on the flags at all.
import nibbler_pkg::*;

module branch_cond_eval (
    input  opcode_t i_opcode,
    input  logic    i_zero,
    input  logic    i_carry,
    output logic    o_taken,
    output logic    o_is_cond
);

    // Decode opcode against flags; JMP is unconditional so it never waits on flags.
    always_comb begin
        o_taken   = 1'b0;
        o_is_cond = 1'b0;
        case (i_opcode)
            OP_JC: begin
                o_taken   = i_carry;
                o_is_cond = 1'b1;
            end
            OP_JNC: begin
                o_taken   = ~i_carry;
                o_is_cond = 1'b1;
            end
            OP_JZ: begin
                o_taken   = i_zero;
                o_is_cond = 1'b1;
            end
            OP_JNZ: begin
                o_taken   = ~i_zero;
                o_is_cond = 1'b1;
            end
            OP_JMP: begin
                o_taken   = 1'b1;
            end
            default: begin
                o_taken   = 1'b0;
                o_is_cond = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/nibbler_branch_ctrl.sv
// Nibbler program-counter owner. Runs FETCH/EXEC per instruction, resolves
// conditional jumps from the Flags outputs and holds EXEC while the flags are
// being rewritten under a conditional jump, so the jump sees settled flags.
//
// Handshake: there is no valid/ready pair. enable=1 advances the phase on the
// clock edge; enable=0 freezes every architectural register, and the pulse
// outputs (branch_taken, stall) read 0 on the cycle after a frozen edge.
import nibbler_pkg::*;

module nibbler_branch_ctrl #(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [15:0]       instr,
    input  logic              zero,
    input  logic              carry,
    input  logic              flags_wr,
    output logic [ADDR_W-1:0] pc,
    output logic              phase,
    output logic              branch_taken,
    output logic              stall,
    output logic [CNT_W-1:0]  taken_count
);

    phase_t            r_state;
    logic [15:0]       r_ir;
    logic [ADDR_W-1:0] r_pc;
    logic              r_branch_taken;
    logic              r_stall;
    logic [CNT_W-1:0]  r_taken_count;

    opcode_t           w_opcode;
    logic [ADDR_W-1:0] w_target;
    logic              w_taken;
    logic              w_is_cond;
    logic              w_hazard;

    assign w_opcode = opcode_t'(r_ir[OPC_MSB:OPC_LSB]);
    assign w_target = r_ir[ADDR_W-1:0];
    // A conditional jump must not read flags on the same edge they change.
    assign w_hazard = w_is_cond & flags_wr;

    branch_cond_eval u_cond (
        .i_opcode  (w_opcode),
        .i_zero    (zero),
        .i_carry   (carry),
        .o_taken   (w_taken),
        .o_is_cond (w_is_cond)
    );

    // FETCH/EXEC sequencer with pc, ir, taken counter and registered pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= FETCH;
            r_ir           <= '0;
            r_pc           <= '0;
            r_branch_taken <= 1'b0;
            r_stall        <= 1'b0;
            r_taken_count  <= '0;
        end else if (!enable) begin
            r_branch_taken <= 1'b0;
            r_stall        <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    r_ir           <= instr;
                    r_state        <= EXEC;
                    r_branch_taken <= 1'b0;
                    r_stall        <= 1'b0;
                end
                EXEC: begin
                    if (w_hazard) begin
                        // Hold in EXEC; re-evaluate once flags_wr drops.
                        r_stall        <= 1'b1;
                        r_branch_taken <= 1'b0;
                    end else begin
                        r_pc           <= w_taken ? w_target : r_pc + ADDR_W'(1);
                        r_branch_taken <= w_taken;
                        r_stall        <= 1'b0;
                        if (w_taken && (r_taken_count != {CNT_W{1'b1}})) begin
                            r_taken_count <= r_taken_count + CNT_W'(1);
                        end
                        r_state        <= FETCH;
                    end
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

    assign pc           = r_pc;
    assign phase        = r_state;
    assign branch_taken = r_branch_taken;
    assign stall        = r_stall;
    assign taken_count  = r_taken_count;

endmodule
